// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencing stage.
package vend_pkg;

  localparam int unsigned CREDIT_W = 10;
  localparam int unsigned ITEM_W   = 2;

  localparam logic [CREDIT_W-1:0] COIN_QUARTER = CREDIT_W'(25);
  localparam logic [CREDIT_W-1:0] COIN_DIME    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] COIN_NICKEL  = CREDIT_W'(5);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DISPENSE,
    ST_CHANGE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/change_dispenser.sv
// Holds the change owed and pays it out greedily, one registered coin pulse per step.
module change_dispenser
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CREDIT_W-1:0] value,
  input  logic                start,
  output logic                done,
  output logic                quarter,
  output logic                dime,
  output logic                nickel
);

  logic [CREDIT_W-1:0] change_reg;
  logic [CREDIT_W-1:0] src_c;
  logic [CREDIT_W-1:0] coin_c;
  logic                quarter_c;
  logic                dime_c;
  logic                nickel_c;

  // A same-edge load and step (refund) pays from the incoming value directly.
  always_comb begin
    src_c     = load ? value : change_reg;
    coin_c    = '0;
    quarter_c = 1'b0;
    dime_c    = 1'b0;
    nickel_c  = 1'b0;
    if (src_c >= COIN_QUARTER) begin
      quarter_c = 1'b1;
      coin_c    = COIN_QUARTER;
    end else if (src_c >= COIN_DIME) begin
      dime_c = 1'b1;
      coin_c = COIN_DIME;
    end else if (src_c >= COIN_NICKEL) begin
      nickel_c = 1'b1;
      coin_c   = COIN_NICKEL;
    end
  end

  // done marks a step that found less than a nickel left; residue is forfeited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_reg <= '0;
      done       <= 1'b0;
      quarter    <= 1'b0;
      dime       <= 1'b0;
      nickel     <= 1'b0;
    end else begin
      done    <= start && !(quarter_c || dime_c || nickel_c);
      quarter <= start && quarter_c;
      dime    <= start && dime_c;
      nickel  <= start && nickel_c;
      if (start) begin
        change_reg <= src_c - coin_c;
      end else if (load) begin
        change_reg <= value;
      end
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vend sequencer: price check, timed dispense, greedy change return, counter clear.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0          = 65,
  parameter int unsigned PRICE1          = 75,
  parameter int unsigned PRICE2          = 100,
  parameter int unsigned PRICE3          = 125,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [CREDIT_W-1:0] inCredit,
  input  logic                inSelectValid,
  input  logic [ITEM_W-1:0]   inSelect,
  input  logic                inCancel,
  output logic                outBusy,
  output logic                outDispense,
  output logic [ITEM_W-1:0]   outItem,
  output logic                outInsufficient,
  output logic                outRetQuarter,
  output logic                outRetDime,
  output logic                outRetNickel,
  output logic                outClearCount
);

  localparam int unsigned DCNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DISPENSE_CYCLES - 1);

  state_e              state;
  state_e              state_next;
  logic [ITEM_W-1:0]   item_reg;
  logic [ITEM_W-1:0]   item_next;
  logic [CREDIT_W-1:0] price_reg;
  logic [CREDIT_W-1:0] price_next;
  logic [CREDIT_W-1:0] credit_reg;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] sel_price_c;
  logic [CREDIT_W-1:0] load_value_c;
  logic [DCNT_W-1:0]   dcnt;
  logic [DCNT_W-1:0]   dcnt_next;
  logic                load_c;
  logic                start_c;
  logic                insuff_c;
  logic                change_done;

  always_comb begin
    case (inSelect)
      2'd0:    sel_price_c = CREDIT_W'(PRICE0);
      2'd1:    sel_price_c = CREDIT_W'(PRICE1);
      2'd2:    sel_price_c = CREDIT_W'(PRICE2);
      default: sel_price_c = CREDIT_W'(PRICE3);
    endcase
  end

  // Next-state and datapath control; strobes are only looked at in IDLE.
  always_comb begin
    state_next   = state;
    item_next    = item_reg;
    price_next   = price_reg;
    credit_next  = credit_reg;
    dcnt_next    = dcnt;
    load_c       = 1'b0;
    load_value_c = '0;
    insuff_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inCancel) begin
          load_c       = 1'b1;
          load_value_c = inCredit;
          state_next   = ST_CHANGE;
        end else if (inSelectValid) begin
          item_next   = inSelect;
          price_next  = sel_price_c;
          credit_next = inCredit;
          state_next  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (credit_reg >= price_reg) begin
          load_c       = 1'b1;
          load_value_c = credit_reg - price_reg;
          dcnt_next    = '0;
          state_next   = ST_DISPENSE;
        end else begin
          insuff_c   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DISPENSE: begin
        if (dcnt == DCNT_LAST) begin
          state_next = ST_CHANGE;
        end else begin
          dcnt_next = dcnt + DCNT_W'(1);
        end
      end
      ST_CHANGE: begin
        if (change_done) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    start_c = (state_next == ST_CHANGE);
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= ST_IDLE;
      item_reg        <= '0;
      price_reg       <= '0;
      credit_reg      <= '0;
      dcnt            <= '0;
      outBusy         <= 1'b0;
      outDispense     <= 1'b0;
      outItem         <= '0;
      outInsufficient <= 1'b0;
      outClearCount   <= 1'b0;
    end else begin
      state           <= state_next;
      item_reg        <= item_next;
      price_reg       <= price_next;
      credit_reg      <= credit_next;
      dcnt            <= dcnt_next;
      outBusy         <= (state_next != ST_IDLE);
      outDispense     <= (state_next == ST_DISPENSE);
      outItem         <= (state_next == ST_DISPENSE) ? item_next : '0;
      outInsufficient <= insuff_c;
      outClearCount   <= (state_next == ST_CLEAR);
    end
  end

  change_dispenser u_change (
    .clk     (clk),
    .rst_n   (resetN),
    .load    (load_c),
    .value   (load_value_c),
    .start   (start_c),
    .done    (change_done),
    .quarter (outRetQuarter),
    .dime    (outRetDime),
    .nickel  (outRetNickel)
  );

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: per-cycle expected output words queued at acceptance.
module tb_vend_controller;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic [9:0] inCredit;
  logic       inSelectValid;
  logic [1:0] inSelect;
  logic       inCancel;
  logic       outBusy;
  logic       outDispense;
  logic [1:0] outItem;
  logic       outInsufficient;
  logic       outRetQuarter;
  logic       outRetDime;
  logic       outRetNickel;
  logic       outClearCount;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE0(65), .PRICE1(75), .PRICE2(100), .PRICE3(125), .DISPENSE_CYCLES(D)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .inCredit        (inCredit),
    .inSelectValid   (inSelectValid),
    .inSelect        (inSelect),
    .inCancel        (inCancel),
    .outBusy         (outBusy),
    .outDispense     (outDispense),
    .outItem         (outItem),
    .outInsufficient (outInsufficient),
    .outRetQuarter   (outRetQuarter),
    .outRetDime      (outRetDime),
    .outRetNickel    (outRetNickel),
    .outClearCount   (outClearCount)
  );

  // {busy, dispense, item[1:0], insufficient, quarter, dime, nickel, clear}
  logic [8:0] obs;
  assign obs = {outBusy, outDispense, outItem, outInsufficient,
                outRetQuarter, outRetDime, outRetNickel, outClearCount};

  typedef struct packed {
    logic [8:0] word;
    int         txn;
    int         idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   txn_id      = 0;
  int   push_idx    = 0;
  bit   mon_en      = 1'b0;
  int   prices[4]   = '{65, 75, 100, 125};

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (busy,disp,item2,ins,q,d,n,clr)", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mk(input bit busy, input bit disp, input int item,
                                    input bit ins, input bit q, input bit d, input bit n,
                                    input bit clr);
    return {busy, disp, 2'(item), ins, q, d, n, clr};
  endfunction

  task automatic push(input logic [8:0] w);
    sb.push_back('{word: w, txn: txn_id, idx: push_idx});
    push_idx++;
  endtask

  // Expected cycle-by-cycle outputs starting the cycle after acceptance.
  task automatic model_txn(input int credit, input int item, input bit refund);
    int c;
    int nq;
    int nd;
    int nn;
    txn_id++;
    push_idx = 0;
    if (refund) begin
      c = credit;
    end else begin
      push(mk(1, 0, 0, 0, 0, 0, 0, 0));
      if (credit < prices[item]) begin
        push(mk(0, 0, 0, 1, 0, 0, 0, 0));
        return;
      end
      for (int i = 0; i < int'(D); i++) push(mk(1, 1, item, 0, 0, 0, 0, 0));
      c = credit - prices[item];
    end
    nq = c / 25;
    nd = (c % 25) / 10;
    nn = ((c % 25) % 10) / 5;
    for (int i = 0; i < nq; i++) push(mk(1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < nd; i++) push(mk(1, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < nn; i++) push(mk(1, 0, 0, 0, 0, 0, 1, 0));
    push(mk(1, 0, 0, 0, 0, 0, 0, 0));
    push(mk(1, 0, 0, 0, 0, 0, 0, 1));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq($sformatf("txn%0d.cyc%0d", mon_e.txn, mon_e.idx), obs, mon_e.word);
      end else begin
        check_eq("idle", obs, 9'h000);
      end
    end
  end

  task automatic vend(input int credit, input int item);
    @(posedge clk); #1;
    inCredit      = 10'(credit);
    inSelect      = 2'(item);
    inSelectValid = 1'b1;
    @(posedge clk); #1;
    inSelectValid = 1'b0;
    model_txn(credit, item, 1'b0);
  endtask

  task automatic refund(input int credit, input bit with_select);
    @(posedge clk); #1;
    inCredit      = 10'(credit);
    inSelect      = 2'd0;
    inCancel      = 1'b1;
    inSelectValid = with_select;
    @(posedge clk); #1;
    inCancel      = 1'b0;
    inSelectValid = 1'b0;
    model_txn(credit, 0, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", 9'(sb.size()), 9'h000);
    sb.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetN        = 1'b0;
    inCredit      = '0;
    inSelectValid = 1'b0;
    inSelect      = '0;
    inCancel      = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("reset_state", obs, 9'h000);
    resetN = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    vend(75, 0);            wait_idle();
    vend(50, 0);            wait_idle();
    vend(75, 0);            wait_idle();
    refund(90, 1'b0);       wait_idle();
    vend(100, 2);           wait_idle();
    vend(103, 2);           wait_idle();
    refund(40, 1'b1);       wait_idle();

    // Strobes arriving mid-dispense must be dropped.
    vend(150, 3);
    @(posedge clk); #1;
    inCredit = 10'd300; inSelect = 2'd1; inSelectValid = 1'b1;
    @(posedge clk); #1;
    inSelectValid = 1'b0; inCancel = 1'b1;
    @(posedge clk); #1;
    inCancel = 1'b0;
    wait_idle();

    // Reset in the second dispense cycle aborts everything.
    vend(100, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    resetN = 1'b0;
    #1;
    check_eq("reset_async", obs, 9'h000);
    sb.delete();
    repeat (2) @(posedge clk); #1;
    resetN = 1'b1;
    repeat (12) @(posedge clk);
    vend(130, 1);           wait_idle();

    for (int i = 0; i < 8; i++) begin
      int cr;
      int it;
      cr = int'($urandom_range(0, 320));
      it = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) refund(cr, 1'b0);
      else vend(cr, it);
      wait_idle();
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
